// File: rtl/uart_pkg.sv
//============================================================================
// uart_pkg: shared UART types, default sizing and parity helper
// Revision 1.0
//============================================================================
`default_nettype none

package uart_pkg;

   localparam int DEFAULT_DATA_WIDTH        = 8;
   localparam int DEFAULT_OVERSAMPLING_RATE = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // data_xor is the XOR-reduction of the data word; odd parity inverts it.
   function automatic logic parity_bit(input logic data_xor, input logic odd);
      return data_xor ^ odd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_os_counter.sv
//============================================================================
// uart_os_counter: counts oversample ticks, strobes bit_end on the last one
// Revision 1.0
//============================================================================
`default_nettype none

module uart_os_counter #(
   parameter int OVERSAMPLING_RATE = 16,
   parameter int CNT_WIDTH         = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick_en,
   output logic bit_end
);

   localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(OVERSAMPLING_RATE - 1);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   // bit_end is combinational so the consumer can act in the same cycle the count wraps.
   assign bit_end = !clr && tick_en && (cnt_q == C_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick_en) begin
         cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
//============================================================================
// uart_tx_ctrl: UART transmit sequencer (start, data, parity, stop bits)
// Revision 1.0
//============================================================================
`default_nettype none

module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
   parameter int OVERSAMPLING_RATE = DEFAULT_OVERSAMPLING_RATE,
   parameter int CNT_WIDTH         = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_en,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  two_stop,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int                IDX_W      = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   uart_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  two_stop_q, two_stop_d;
   logic                  stop2_q, stop2_d;
   logic                  tx_q, tx_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  bit_end;

   // Holding the counter clear while idle discards a tick in the accept cycle.
   uart_os_counter #(
      .OVERSAMPLING_RATE (OVERSAMPLING_RATE),
      .CNT_WIDTH         (CNT_WIDTH)
   ) u_os_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_q == ST_IDLE),
      .tick_en (tick_en),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      stop2_d    = stop2_q;
      tx_d       = tx_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_valid && ready_q) begin
               shift_d    = tx_data;
               par_en_d   = parity_en;
               par_bit_d  = parity_bit(^tx_data, parity_odd);
               two_stop_d = two_stop;
               idx_d      = '0;
               stop2_d    = 1'b0;
               state_d    = ST_START;
               tx_d       = 1'b0;
               ready_d    = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == C_LAST_IDX) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
                  tx_d    = par_en_q ? par_bit_q : 1'b1;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (two_stop_q && !stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         idx_q      <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         stop2_q    <= stop2_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
//============================================================================
// tb_uart_tx_ctrl: randomized bench against a tick-count frame model
// Revision 1.0
//============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

   localparam int DW  = 8;
   localparam int OSR = 16;
   localparam int CW  = 4;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          tick_en    = 1'b0;
   logic [DW-1:0] tx_data    = '0;
   logic          tx_valid   = 1'b0;
   logic          parity_en  = 1'b0;
   logic          parity_odd = 1'b0;
   logic          two_stop   = 1'b0;
   logic          tx_ready, tx, busy, done;

   uart_tx_ctrl #(
      .DATA_WIDTH        (DW),
      .OVERSAMPLING_RATE (OSR),
      .CNT_WIDTH         (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_en    (tick_en),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .two_stop   (two_stop),
      .tx         (tx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Tick source: 0 off, 1 periodic, 2 random, 3 every cycle
   int tick_mode   = 0;
   int tick_period = 4;
   int tick_div    = 0;
   initial forever begin
      @(negedge clk);
      case (tick_mode)
         1: begin
            if (tick_div >= tick_period - 1) begin
               tick_en  = 1'b1;
               tick_div = 0;
            end else begin
               tick_en  = 1'b0;
               tick_div++;
            end
         end
         2:       tick_en = 1'($urandom_range(0, 1));
         3:       tick_en = 1'b1;
         default: tick_en = 1'b0;
      endcase
   end

   // Reference model: a frame is a list of bits, bit n spans ticks [n*OSR, (n+1)*OSR)
   logic m_tx = 1'b1, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
   bit   m_active = 1'b0;
   int   m_k = 0, m_nbits = 0, m_accepts = 0;
   logic m_bits [0:11];

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_active = 1'b0;
         m_tx = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (!m_active) begin
            if (tx_valid) begin
               int n;
               m_bits[0] = 1'b0;
               for (int i = 0; i < DW; i++) m_bits[1 + i] = tx_data[i];
               n = 1 + DW;
               if (parity_en) begin
                  m_bits[n] = (($countones(tx_data) % 2) == 1) ^ parity_odd;
                  n++;
               end
               m_bits[n] = 1'b1; n++;
               if (two_stop) begin
                  m_bits[n] = 1'b1; n++;
               end
               m_nbits  = n;
               m_k      = 0;
               m_active = 1'b1;
               m_accepts++;
               m_tx = 1'b0; m_ready = 1'b0; m_busy = 1'b1;
            end
         end else if (tick_en) begin
            m_k++;
            if (m_k == m_nbits * OSR) begin
               m_active = 1'b0;
               m_tx = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end else begin
               m_tx = m_bits[m_k / OSR];
            end
         end
      end
   end

   bit chk_en = 1'b0;
   int dut_dones = 0;
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("tx", 32'(tx), 32'(m_tx));
         chk("tx_ready", 32'(tx_ready), 32'(m_ready));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         if (done === 1'b1) dut_dones++;
      end
   end

   // Presents a word and returns at the negedge right after it is accepted (tx_valid left high).
   task automatic send(input logic [DW-1:0] d, input logic pe, input logic po, input logic ts);
      int a0;
      int waited;
      a0 = m_accepts;
      @(negedge clk);
      tx_data = d; parity_en = pe; parity_odd = po; two_stop = ts; tx_valid = 1'b1;
      waited = 0;
      while (m_accepts == a0 && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      if (m_accepts == a0) chk("accept_timeout", 32'(waited), 32'd0);
   endtask

   task automatic wait_idle();
      int waited;
      waited = 0;
      while (m_active && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      if (m_active) chk("idle_timeout", 32'(waited), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_k(input int k);
      int waited;
      waited = 0;
      while (m_active && m_k < k && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      if (m_k < k) chk("tick_wait_timeout", 32'(m_k), 32'(k));
   endtask

   initial begin
      int d0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // idle with ticks running, no traffic
      tick_mode = 1; tick_period = 4;
      repeat (400) @(negedge clk);
      chk("idle_no_accept", 32'(m_accepts), 32'd0);

      // basic 8N1
      d0 = dut_dones;
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      tx_valid = 1'b0;
      wait_idle();
      chk("8n1_dones", 32'(dut_dones - d0), 32'd1);

      // parity + two stop, odd then even
      send(8'h03, 1'b1, 1'b1, 1'b1); tx_valid = 1'b0; wait_idle();
      send(8'h03, 1'b1, 1'b0, 1'b1); tx_valid = 1'b0; wait_idle();

      // back-to-back with tx_valid held
      d0 = dut_dones;
      tick_mode = 3;
      send(8'h55, 1'b0, 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0, 1'b0);
      tx_valid = 1'b0;
      wait_idle();
      repeat (40) @(negedge clk);
      chk("b2b_dones", 32'(dut_dones - d0), 32'd2);

      // config change during DATA bits
      tick_mode = 2;
      send(8'h96, 1'b0, 1'b0, 1'b0); tx_valid = 1'b0;
      wait_k(3 * OSR);
      parity_en = 1'b1; two_stop = 1'b1; parity_odd = 1'b1;
      wait_idle();
      send(8'h96, 1'b1, 1'b1, 1'b1); tx_valid = 1'b0; wait_idle();

      // reset during DATA bit 3
      d0 = dut_dones;
      send(8'hC3, 1'b1, 1'b0, 1'b1); tx_valid = 1'b0;
      wait_k(4 * OSR + 3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("reset_no_done", 32'(dut_dones - d0), 32'd0);

      // tick stall mid-bit
      tick_mode = 1; tick_period = 2;
      send(8'h3C, 1'b0, 1'b0, 1'b1); tx_valid = 1'b0;
      wait_k(2 * OSR + 5);
      tick_mode = 0;
      repeat (50) @(negedge clk);
      tick_mode = 1;
      wait_idle();

      // random traffic
      for (int f = 0; f < 20; f++) begin
         tick_mode   = int'($urandom_range(1, 3));
         tick_period = int'($urandom_range(1, 4));
         send(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 0) tx_valid = 1'b0;
         wait_k(OSR / 2);
         tx_valid = 1'b0;
         wait_idle();
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
